// File: rtl/cam_ctrl.sv
// cam_ctrl: sequencer for the multipumped BRAM-based CAM storage.
// Slices keys into per-pump row addresses, runs searches and read-modify-write updates.
module cam_ctrl #(
    parameter int unsigned BRAM_DEPTH       = 512,
    parameter int unsigned CAM_DEPTH        = 64,
    parameter int unsigned MULTIPUMP_FACTOR = 2,
    localparam int unsigned ADDR_W  = $clog2(BRAM_DEPTH),
    localparam int unsigned IDX_W   = $clog2(CAM_DEPTH),
    localparam int unsigned SEL_W   = $clog2(MULTIPUMP_FACTOR),
    localparam int unsigned SLICE_W = ADDR_W - SEL_W,
    localparam int unsigned KEY_W   = MULTIPUMP_FACTOR * SLICE_W
) (
    input  logic                 clk,
    input  logic                 sys_rstn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [KEY_W-1:0]     req_key,
    input  logic [IDX_W-1:0]     req_idx,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_hit,
    output logic [IDX_W-1:0]     rsp_idx,
    output logic [CAM_DEPTH-1:0] rsp_match,
    output logic                 rsp_err,
    output logic                 init_done,
    output logic                 cam_chip_en,
    output logic                 cam_wr_en,
    output logic [ADDR_W-1:0]    cam_addr,
    output logic [CAM_DEPTH-1:0] cam_wdata,
    input  logic [CAM_DEPTH-1:0] cam_rdata
);

    localparam logic [1:0] OpSearch = 2'b00;
    localparam logic [1:0] OpWrite  = 2'b01;
    localparam logic [1:0] OpDelete = 2'b10;
    localparam logic [1:0] OpClear  = 2'b11;

    localparam logic [ADDR_W-1:0] LastRow   = ADDR_W'(BRAM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] SrchCap   = ADDR_W'(MULTIPUMP_FACTOR);
    localparam logic [ADDR_W-1:0] LastSlice = ADDR_W'(MULTIPUMP_FACTOR - 1);

    typedef enum logic [2:0] {
        StInit, StIdle, StSrch, StClrRd, StClrWr, StSetRd, StSetWr, StRsp
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      cnt_q, cnt_d;
    logic [1:0]             op_q, op_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [KEY_W-1:0]       key_q, key_d;
    logic [KEY_W-1:0]       new_key_q, new_key_d;
    logic [CAM_DEPTH-1:0]   acc_q, acc_d;
    logic [CAM_DEPTH-1:0]   valid_q, valid_d;
    logic [KEY_W-1:0]       shadow_q [CAM_DEPTH];
    logic [KEY_W-1:0]       shadow_d [CAM_DEPTH];
    logic                   init_done_q, init_done_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_hit_q, rsp_hit_d;
    logic [IDX_W-1:0]       rsp_idx_q, rsp_idx_d;
    logic [CAM_DEPTH-1:0]   rsp_match_q, rsp_match_d;
    logic                   rsp_err_q, rsp_err_d;

    logic                   done_plain, done_err;
    logic [SEL_W-1:0]       sel;
    logic [SLICE_W-1:0]     slice;
    logic [ADDR_W-1:0]      slice_addr;
    logic [CAM_DEPTH-1:0]   idx_mask;
    logic [CAM_DEPTH-1:0]   srch_match;
    logic [IDX_W-1:0]       srch_idx;

    // The pump counter doubles as slice selector in SRCH and the RMW states.
    assign sel        = cnt_q[SEL_W-1:0];
    assign slice      = key_q[sel * SLICE_W +: SLICE_W];
    assign slice_addr = {sel, slice};
    assign idx_mask   = {{(CAM_DEPTH - 1){1'b0}}, 1'b1} << idx_q;

    always_comb begin
        srch_match = acc_q & cam_rdata & valid_q;
        srch_idx   = '0;
        for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
            if (srch_match[i]) srch_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!sys_rstn) begin
            state_q     <= StInit;
            cnt_q       <= '0;
            op_q        <= OpSearch;
            idx_q       <= '0;
            key_q       <= '0;
            new_key_q   <= '0;
            acc_q       <= '0;
            valid_q     <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_match_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            key_q       <= key_d;
            new_key_q   <= new_key_d;
            acc_q       <= acc_d;
            valid_q     <= valid_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_match_q <= rsp_match_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Shadow keys are only meaningful under a valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        idx_d       = idx_q;
        key_d       = key_q;
        new_key_d   = new_key_q;
        acc_d       = acc_q;
        valid_d     = valid_q;
        shadow_d    = shadow_q;
        init_done_d = init_done_q;
        rsp_valid_d = rsp_valid_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_idx_d   = rsp_idx_q;
        rsp_match_d = rsp_match_q;
        rsp_err_d   = rsp_err_q;
        done_plain  = 1'b0;
        done_err    = 1'b0;

        unique case (state_q)
            StInit: begin
                if (cnt_q == LastRow) begin
                    cnt_d       = '0;
                    init_done_d = 1'b1;
                    if (op_q == OpClear) done_plain = 1'b1;
                    else state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StIdle: begin
                if (req_valid) begin
                    op_d  = req_op;
                    idx_d = req_idx;
                    cnt_d = '0;
                    unique case (req_op)
                        OpSearch: begin
                            key_d   = req_key;
                            acc_d   = '1;
                            state_d = StSrch;
                        end
                        OpWrite: begin
                            new_key_d = req_key;
                            if (valid_q[req_idx]) begin
                                key_d   = shadow_q[req_idx];
                                state_d = StClrRd;
                            end else begin
                                key_d   = req_key;
                                state_d = StSetRd;
                            end
                        end
                        OpDelete: begin
                            if (valid_q[req_idx]) begin
                                key_d   = shadow_q[req_idx];
                                state_d = StClrRd;
                            end else begin
                                done_plain = 1'b1;
                                done_err   = 1'b1;
                            end
                        end
                        default: begin
                            valid_d = '0;
                            state_d = StInit;
                        end
                    endcase
                end
            end
            StSrch: begin
                // Row for pump cnt-1 arrives while cnt is presented.
                if (cnt_q != '0) acc_d = acc_q & cam_rdata;
                if (cnt_q == SrchCap) begin
                    state_d     = StRsp;
                    rsp_valid_d = 1'b1;
                    rsp_hit_d   = |srch_match;
                    rsp_idx_d   = srch_idx;
                    rsp_match_d = srch_match;
                    rsp_err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StClrRd: state_d = StClrWr;
            StClrWr: begin
                if (cnt_q == LastSlice) begin
                    cnt_d = '0;
                    if (op_q == OpWrite) begin
                        key_d   = new_key_q;
                        state_d = StSetRd;
                    end else begin
                        valid_d[idx_q] = 1'b0;
                        done_plain     = 1'b1;
                    end
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = StClrRd;
                end
            end
            StSetRd: state_d = StSetWr;
            StSetWr: begin
                if (cnt_q == LastSlice) begin
                    cnt_d            = '0;
                    valid_d[idx_q]   = 1'b1;
                    shadow_d[idx_q]  = key_q;
                    done_plain       = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = StSetRd;
                end
            end
            StRsp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StInit;
        endcase

        if (done_plain) begin
            state_d     = StRsp;
            rsp_valid_d = 1'b1;
            rsp_hit_d   = 1'b0;
            rsp_idx_d   = '0;
            rsp_match_d = '0;
            rsp_err_d   = done_err;
        end
    end

    always_comb begin
        req_ready   = (state_q == StIdle);
        cam_chip_en = 1'b0;
        cam_wr_en   = 1'b0;
        cam_addr    = '0;
        cam_wdata   = '0;
        unique case (state_q)
            StInit: begin
                cam_chip_en = 1'b1;
                cam_wr_en   = 1'b1;
                cam_addr    = cnt_q;
            end
            StSrch: begin
                cam_chip_en = (cnt_q != SrchCap);
                cam_addr    = slice_addr;
            end
            StClrRd, StSetRd: begin
                cam_chip_en = 1'b1;
                cam_addr    = slice_addr;
            end
            StClrWr: begin
                cam_chip_en = 1'b1;
                cam_wr_en   = 1'b1;
                cam_addr    = slice_addr;
                cam_wdata   = cam_rdata & ~idx_mask;
            end
            StSetWr: begin
                cam_chip_en = 1'b1;
                cam_wr_en   = 1'b1;
                cam_addr    = slice_addr;
                cam_wdata   = cam_rdata | idx_mask;
            end
            default: ;
        endcase
        // Storage stays quiet while held in reset.
        if (!sys_rstn) begin
            cam_chip_en = 1'b0;
            cam_wr_en   = 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_idx   = rsp_idx_q;
    assign rsp_match = rsp_match_q;
    assign rsp_err   = rsp_err_q;
    assign init_done = init_done_q;

endmodule
